imem_fetch: RTL and testbench
=============================

# imem_fetch

Instruction-fetch responder on the instruction side of the single-cycle MIPS core. It takes the instruction address `ia` from the program counter and returns the 32-bit instruction. It holds a small direct-mapped, one-word-per-line instruction buffer in front of a multi-cycle memory bus. On a miss it asserts `Stall` to freeze the PC until the backing memory acknowledges the fill.

## Interface
- `LINES`, 8, number of buffer lines; power of two, 2..256; index width `IW = log2(LINES)`
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `ia`  in  32  instruction address from PC
- `flush`  in  1  invalidate all buffer lines
- `instr`  out  32  fetched instruction; valid when `Stall`=0 and `misalign`=0
- `Stall`  out  1  to PC; hold `ia`
- `misalign`  out  1  `ia[1:0]` != 0
- `mem_req`  out  1  fill request to backing memory
- `mem_addr`  out  32  word address of fill, `{ia[31:2],2'b00}` latched
- `mem_ack`  in  1  memory data valid, one-cycle pulse
- `mem_rdata`  in  32  fill data, valid with `mem_ack`
- `hit_count`  out  32  saturating count of hit cycles
- `miss_count`  out  32  saturating count of fills started

## Operation
- Address split: index = `ia[IW+1:2]`, tag = `ia[31:IW+2]`. Per line: valid bit, tag, data word.
- Hit = aligned, line valid, and tag equal.
- States: IDLE and FILL.
- IDLE:
  - On hit: `instr` = line data and `Stall`=0 (combinational). `hit_count` increments.
  - On aligned miss: `Stall`=1 in the same cycle. At the edge: latch `mem_addr`, go to FILL, and increment `miss_count`.
- FILL:
  - `mem_req`=1 and `Stall`=1.
  - `mem_addr` is held stable until `mem_ack`.
- FILL on `mem_ack`:
  - Write tag, data and valid to the indexed line at the edge.
  - If `ia[31:2]` still equals the latched address: forward `mem_rdata` to `instr` and drive `Stall`=0 this cycle.
  - Otherwise keep `Stall`=1.
  - Return to IDLE.
- Misaligned `ia`:
  - `misalign`=1, `Stall`=0, `instr`=0. No fill is started and no counter changes. Exception steering belongs to the PC/control path.
- `instr`=0 (MIPS NOP) whenever `Stall`=1 or `misalign`=1.
- `flush`:
  - Clears all valid bits at the edge. Allowed in either state.
  - If `flush` coincides with a fill write, flush wins: the line stays invalid, but the forwarded `instr` still presents `mem_rdata` that cycle.
  - `flush` does not abort an in-progress FILL.
- Counters saturate at 0xFFFFFFFF and never wrap.
- Reset (async, `reset`=0) drives:
  - state IDLE, all valid bits 0
  - `mem_req`=0, `mem_addr`=0
  - `hit_count`=0, `miss_count`=0
- Reset asserted mid-FILL abandons the request immediately. The memory must tolerate `mem_req` dropping without ack, and a late `mem_ack` in IDLE is ignored.

## Timing
- Hit: zero-cycle latency, combinational from `ia`.
- Miss: cycle 0 detect (`Stall`=1); `mem_req` rises at cycle 1; the ack arriving at cycle k≥1 releases `Stall` in cycle k. Miss penalty = k stall cycles.
- `mem_ack` outside FILL is ignored.
- After a fill the next `ia` is new (PC advances), so back-to-back misses re-enter FILL with one IDLE cycle between requests.
- `mem_req` is registered (state-decoded). `Stall`, `instr` and `misalign` are combinational from `ia`, state and `mem_ack`.

## Test plan
- **Cold miss:** deassert reset, `ia`=0x80000000. Expect `Stall`=1, then `mem_req`=1 with `mem_addr`=0x80000000. `mem_ack` 3 cycles later with `mem_rdata`=0x3C1D1000 gives `instr`=0x3C1D1000 and `Stall`=0 that cycle, and `miss_count`=1.
- **Hit after fill:** revisit 0x80000000. Expect `Stall`=0, `instr`=0x3C1D1000, `mem_req`=0, and `hit_count` incremented.
- **Conflict:** with `LINES`=8, fill 0x80000000 then 0x80000020 (both index 0). Re-access 0x80000000 misses again, and `miss_count`=3.
- **Flush:** after hits, pulse `flush` one cycle, then re-access. Expect a miss with `Stall`=1. When `flush` coincides with `mem_ack`, the data is forwarded but the next access misses.
- **Misaligned:** `ia`=0x80000002. Expect `misalign`=1, `Stall`=0, `instr`=0, no `mem_req`, counters unchanged.
- **Reset mid-fill:** assert `reset`=0 two cycles into FILL. Expect `mem_req`=0 immediately and all lines invalid. A stray `mem_ack` after release is ignored, and the next fetch misses.

Source files
------------

// File: rtl/imem_fetch.sv
// Instruction-fetch front end: direct-mapped, one-word-per-line buffer that
// stalls the PC while a missing word is filled from a multi-cycle memory bus.
module imem_fetch #(
  parameter int LINES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ia,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        Stall,
  output logic        misalign,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - IW;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state;
  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          aligned;
  logic          hit;
  logic          fill_done;
  logic          fwd;

  assign idx      = ia[IW+1:2];
  assign tag      = ia[31:IW+2];
  assign fill_idx = mem_addr[IW+1:2];
  assign fill_tag = mem_addr[31:IW+2];
  assign aligned  = (ia[1:0] == 2'b00);
  assign hit      = aligned && valid[idx] && (tag_mem[idx] == tag);

  assign fill_done = (state == FILL) && mem_ack;
  // Forward only if the PC is still asking for the word being filled.
  assign fwd       = fill_done && (ia[31:2] == mem_addr[31:2]);

  assign misalign = !aligned;

  always_comb begin
    Stall = 1'b0;
    instr = 32'h0000_0000;
    if (aligned) begin
      if (state == IDLE) begin
        if (hit) instr = data_mem[idx];
        else     Stall = 1'b1;
      end else begin
        if (fwd) instr = mem_rdata;
        else     Stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      hit_count  <= 32'h0000_0000;
      miss_count <= 32'h0000_0000;
      valid      <= '0;
    end else begin
      if (state == IDLE) begin
        if (aligned && !hit) begin
          state    <= FILL;
          mem_req  <= 1'b1;
          mem_addr <= {ia[31:2], 2'b00};
          if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end else if (hit) begin
          if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
        end
      end else if (mem_ack) begin
        state   <= IDLE;
        mem_req <= 1'b0;
      end

      // Flush beats a coincident fill: the line stays invalid.
      if (flush)          valid           <= '0;
      else if (fill_done) valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ia = 32'h8000_0000;
  logic        flush = 1'b0;
  logic [31:0] instr;
  logic        Stall;
  logic        misalign;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        stall;
    logic        mis;
    logic        req;
    logic [31:0] addr;
    logic [31:0] hc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];

  imem_fetch #(.LINES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .ia         (ia),
    .flush      (flush),
    .instr      (instr),
    .Stall      (Stall),
    .misalign   (misalign),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "instr",      instr,             e.instr);
        chk(e.name, "Stall",      {31'b0, Stall},    {31'b0, e.stall});
        chk(e.name, "misalign",   {31'b0, misalign}, {31'b0, e.mis});
        chk(e.name, "mem_req",    {31'b0, mem_req},  {31'b0, e.req});
        chk(e.name, "mem_addr",   mem_addr,          e.addr);
        chk(e.name, "hit_count",  hit_count,         e.hc);
        chk(e.name, "miss_count", miss_count,        e.mc);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue what the
  // DUT must show during that cycle.
  task automatic step(input string nm, input logic rst, input logic [31:0] a,
                      input logic fl, input logic ack, input logic [31:0] rd,
                      input logic [31:0] e_instr, input logic e_stall, input logic e_mis,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic [31:0] e_hc, input logic [31:0] e_mc);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    ia        = a;
    flush     = fl;
    mem_ack   = ack;
    mem_rdata = rd;
    e.name = nm; e.instr = e_instr; e.stall = e_stall; e.mis = e_mis;
    e.req = e_req; e.addr = e_addr; e.hc = e_hc; e.mc = e_mc;
    sb.push_back(e);
  endtask

  localparam logic [31:0] A0  = 32'h8000_0000;
  localparam logic [31:0] A20 = 32'h8000_0020;
  localparam logic [31:0] D0  = 32'h3C1D_1000;

  initial begin : stim
    int guard;
    repeat (2) @(posedge clk);
    step("reset_state",  0, A0, 0, 0, 0,            32'h0, 1, 0, 0, 32'h0, 0, 0);
    @(negedge clk); #1 reset = 1'b1;

    step("cold_fill1",   1, A0, 0, 0, 0,            32'h0, 1, 0, 1, A0, 0, 1);
    step("cold_fill2",   1, A0, 0, 0, 0,            32'h0, 1, 0, 1, A0, 0, 1);
    step("cold_ack",     1, A0, 0, 1, D0,           D0,    0, 0, 1, A0, 0, 1);
    step("hit1",         1, A0, 0, 0, 0,            D0,    0, 0, 0, A0, 0, 1);
    step("hit2",         1, A0, 0, 0, 0,            D0,    0, 0, 0, A0, 1, 1);
    step("conf_miss",    1, A20, 0, 0, 0,           32'h0, 1, 0, 0, A0, 2, 1);
    step("conf_fill",    1, A20, 0, 0, 0,           32'h0, 1, 0, 1, A20, 2, 2);
    step("conf_ack",     1, A20, 0, 1, 32'h2408_0020, 32'h2408_0020, 0, 0, 1, A20, 2, 2);
    step("conf_remiss",  1, A0, 0, 0, 0,            32'h0, 1, 0, 0, A20, 2, 2);
    step("conf_ack_k1",  1, A0, 0, 1, D0,           D0,    0, 0, 1, A0, 2, 3);
    step("l1_miss",      1, 32'h8000_0004, 0, 0, 0, 32'h0, 1, 0, 0, A0, 2, 3);
    step("nofwd_ack",    1, 32'h8000_0008, 0, 1, 32'h1111_1111, 32'h0, 1, 0, 1, 32'h8000_0004, 2, 4);
    step("l1_hit",       1, 32'h8000_0004, 0, 0, 0, 32'h1111_1111, 0, 0, 0, 32'h8000_0004, 2, 4);
    step("l0_hit",       1, A0, 0, 0, 0,            D0,    0, 0, 0, 32'h8000_0004, 3, 4);
    step("flush_hit",    1, A0, 1, 0, 0,            D0,    0, 0, 0, 32'h8000_0004, 4, 4);
    step("post_flush",   1, A0, 0, 0, 0,            32'h0, 1, 0, 0, 32'h8000_0004, 5, 4);
    step("flush_ack",    1, A0, 1, 1, D0,           D0,    0, 0, 1, A0, 5, 5);
    step("flush_won",    1, A0, 0, 0, 0,            32'h0, 1, 0, 0, A0, 5, 5);
    step("refill_ack",   1, A0, 0, 1, D0,           D0,    0, 0, 1, A0, 5, 6);
    step("misalign_ack", 1, 32'h8000_0002, 0, 1, 32'hDEAD_BEEF, 32'h0, 0, 1, 0, A0, 5, 6);
    step("misalign2",    1, 32'h8000_0002, 0, 0, 0, 32'h0, 0, 1, 0, A0, 5, 6);
    step("hit_after_mis",1, A0, 0, 0, 0,            D0,    0, 0, 0, A0, 5, 6);
    step("l4_miss",      1, 32'h8000_0010, 0, 0, 0, 32'h0, 1, 0, 0, A0, 6, 6);
    step("l4_fill",      1, 32'h8000_0010, 0, 0, 0, 32'h0, 1, 0, 1, 32'h8000_0010, 6, 7);
    step("mid_reset",    0, 32'h8000_0010, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0);
    step("stray_ack",    1, 32'h8000_0010, 0, 1, 32'hCAFE_F00D, 32'h0, 1, 0, 0, 32'h0, 0, 0);
    step("rst_fill",     1, 32'h8000_0010, 0, 0, 0, 32'h0, 1, 0, 1, 32'h8000_0010, 0, 1);
    step("rst_ack",      1, 32'h8000_0010, 0, 1, 32'hAC22_0004, 32'hAC22_0004, 0, 0, 1, 32'h8000_0010, 0, 1);
    step("l0_cold",      1, A0, 0, 0, 0,            32'h0, 1, 0, 0, 32'h8000_0010, 0, 1);
    step("l0_ack",       1, A0, 0, 1, D0,           D0,    0, 0, 1, A0, 0, 2);
    step("l4_hit",       1, 32'h8000_0010, 0, 0, 0, 32'hAC22_0004, 0, 0, 0, A0, 0, 2);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
